uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
UART transmitter: the transmit-side counterpart of the UART RX path.
- Accepts a parallel byte with a one-cycle valid strobe.
- Serializes it as start bit, LSB-first data, optional parity bit and stop bit, one bit per CLK cycle.
- CLK is the baud-rate clock supplied by the system clock divider; no oversampling on the TX side.
- Sits between the register file/FIFO read side and the TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (range 5-9).

Ports:
CLK  input  1  baud-rate clock; all state changes on rising edge.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel data to transmit.
DATA_VALID  input  1  high for one or more cycles to request transmission of P_DATA.
PAR_EN  input  1  1 = append parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line; idle high.
Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST low, asynchronous): FSM to IDLE; TX_OUT=1; Busy=0; internal data/parity/config registers cleared; bit counter=0. Takes effect immediately, including mid-frame; a truncated frame is abandoned and not resumed.
- TX_OUT and Busy are registered outputs, driven directly from flops (no combinational path from inputs).
- FSM states:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=data[bit_cnt].
  - PARITY: TX_OUT=parity bit.
  - STOP: TX_OUT=1.
- Acceptance: DATA_VALID is sampled only in IDLE. On an edge with state IDLE and DATA_VALID=1:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - compute parity: even = XOR-reduce of data, odd = its inverse;
  - go to START; TX_OUT=0 and Busy=1 from that edge.
- DATA_VALID in any non-IDLE state is ignored. Input changes mid-frame do not affect the frame in flight.
- Transitions:
  - START -> DATA after 1 cycle.
  - DATA holds DATA_WIDTH cycles; bit_cnt runs 0..DATA_WIDTH-1, LSB first.
  - After the last data bit: PARITY if latched PAR_EN=1, else STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> IDLE after 1 cycle.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity. Busy is high for exactly the frame length.
- Back-to-back: DATA_VALID held high continuously gives one IDLE cycle (TX_OUT=1) between STOP and the next START, so the effective stop period is 2 bits. Minimum inter-frame gap is 1 cycle.
- A level-held DATA_VALID re-triggers on every IDLE cycle. The upstream block must drop it once Busy rises if only one frame is intended.
- bit_cnt is sized ceil(log2(DATA_WIDTH)) bits and resets to 0 on leaving DATA; it must never wrap inside a frame.

Test Plan:
1. Reset, PAR_EN=0, P_DATA=0xA5, DATA_VALID pulse 1 cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy high exactly 10 cycles; then TX_OUT=1, Busy=0.
2. PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 -> 11-bit frame, parity bit 0. Repeat with PAR_TYP=1 -> parity bit 1. Repeat with P_DATA=0x01, PAR_TYP=0 -> parity bit 1.
3. P_DATA=0x3C accepted, then P_DATA changed to 0xFF and DATA_VALID pulsed during the DATA state -> frame carries 0x3C; no second frame; Busy drops after 10 cycles.
4. DATA_VALID held high for 25 cycles with P_DATA=0x55, PAR_EN=0 -> frames start at cycles 1, 12 and 23, each followed by exactly one idle-high cycle.
5. RST asserted low mid-DATA (bit 4 of 0xF0) -> TX_OUT=1 and Busy=0 immediately, without waiting for a clock edge. After release, a new 0x0F request yields a clean 10-cycle frame.
6. DATA_WIDTH=7, PAR_EN=1, PAR_TYP=1, P_DATA=7'h7F -> 10-cycle frame: 0,1,1,1,1,1,1,1,0,1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// one bit per baud-rate clock. TX_OUT and Busy are driven straight from flops.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         bit_cnt, cnt_next, cnt_inc;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  parity_q;
  logic                  load;
  logic                  tx_next;
  logic                  busy_next;

  // Next state, next bit counter and the line level for the state being
  // entered; the line level is registered so it lines up with the new state.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    tx_next    = 1'b1;
    load       = 1'b0;
    cnt_inc    = bit_cnt + CW'(1);
    case (state)
      IDLE: begin
        if (DATA_VALID) begin
          load       = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        state_next = DATA;
        cnt_next   = '0;
        tx_next    = data_q[0];
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          cnt_next = '0;
          if (par_en_q) begin
            state_next = PARITY;
            tx_next    = parity_q;
          end else begin
            state_next = STOP;
            tx_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt_inc;
          tx_next  = data_q[cnt_inc];
        end
      end
      PARITY: begin
        state_next = STOP;
        tx_next    = 1'b1;
      end
      STOP: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, bit counter and registered line outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      TX_OUT  <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
      TX_OUT  <= tx_next;
      Busy    <= busy_next;
    end
  end

  // Frame contents captured at acceptance so later input changes are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else if (load) begin
      data_q   <= P_DATA;
      par_en_q <= PAR_EN;
      parity_q <= (^P_DATA) ^ PAR_TYP;
    end
  end

endmodule
